// File: rtl/safe_lock_controller_pkg.sv
// ============================================================================
//  safe_lock_pkg : shared types and constants for the safe lock controller
//  Rev 1.0
// ============================================================================
`default_nettype none

package safe_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROG    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int c_digit_w  = 4;
  localparam int c_code_len = 4;
  localparam int c_code_w   = c_digit_w * c_code_len;

  localparam logic [c_code_w-1:0] c_default_code = 16'h1234;

endpackage

`default_nettype wire

// File: rtl/safe_lock_controller_lock_timer.sv
// ============================================================================
//  lock_timer : loadable down-counter with zero flag, shared by OPEN/LOCKOUT
//  Rev 1.0
// ============================================================================
`default_nettype none

module lock_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Saturates at zero so a late-sampled zero flag stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/safe_lock_controller.sv
// ============================================================================
//  safe_lock_controller : code entry, compare, lockout and auto-relock FSM
//  Rev 1.0
// ============================================================================
`default_nettype none

module safe_lock_controller
  import safe_lock_pkg::*;
#(
  parameter int DIGIT_W        = c_digit_w,
  parameter int CODE_LEN       = c_code_len,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = c_default_code,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           digit_valid,
  input  logic [DIGIT_W-1:0]             digit,
  output logic                           digit_ready,
  input  logic                           cancel,
  input  logic                           lock_now,
  input  logic                           change_req,
  output logic                           unlock,
  output logic                           alarm,
  output logic                           bad_code,
  output logic                           code_changed,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int c_width   = DIGIT_W * CODE_LEN;
  localparam int c_fail_w  = $clog2(MAX_FAILS + 1);
  localparam int c_cnt_w   = $clog2(CODE_LEN + 1);
  localparam int c_timer_w = $clog2((LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                     : UNLOCK_CYCLES);

  localparam logic [c_fail_w:0]    c_max_fails     = (c_fail_w+1)'(MAX_FAILS);
  localparam logic [c_cnt_w-1:0]   c_last_digit    = c_cnt_w'(CODE_LEN - 1);
  localparam logic [c_timer_w-1:0] c_unlock_load   = c_timer_w'(UNLOCK_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_lockout_load  = c_timer_w'(LOCKOUT_CYCLES - 1);

  state_t                r_state;
  logic [c_width-1:0]    r_code;
  logic [c_width-1:0]    r_buffer;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_fail_w-1:0]   r_fail_count;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_match;
  logic [c_fail_w:0]     w_fail_inc;
  logic [c_width-1:0]    w_shifted;
  logic                  w_timer_load;
  logic [c_timer_w-1:0]  w_timer_load_value;
  logic                  w_timer_en;
  logic                  w_timer_zero;

  assign digit_ready = (r_state == ENTRY) || (r_state == PROG);
  assign w_accept    = digit_valid && digit_ready;
  assign w_last      = (r_count == c_last_digit);
  assign w_shifted   = {r_buffer[c_width-DIGIT_W-1:0], digit};
  assign w_match     = (r_buffer == r_code);
  assign w_fail_inc  = {1'b0, r_fail_count} + 1'b1;
  assign fail_count  = r_fail_count;

  // The timer is only loaded out of CHECK, toward OPEN or LOCKOUT.
  assign w_timer_load       = (r_state == CHECK) && (w_match || (w_fail_inc >= c_max_fails));
  assign w_timer_load_value = w_match ? c_unlock_load : c_lockout_load;
  assign w_timer_en         = (r_state == OPEN) || (r_state == LOCKOUT);

  lock_timer #(
    .WIDTH (c_timer_w)
  ) u_lock_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_timer_load),
    .load_value (w_timer_load_value),
    .en         (w_timer_en),
    .zero       (w_timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ENTRY;
      r_code       <= DEFAULT_CODE;
      r_buffer     <= '0;
      r_count      <= '0;
      r_fail_count <= '0;
      unlock       <= 1'b0;
      alarm        <= 1'b0;
      bad_code     <= 1'b0;
      code_changed <= 1'b0;
    end else begin
      bad_code     <= 1'b0;
      code_changed <= 1'b0;
      case (r_state)
        ENTRY: begin
          // cancel wins over a digit accepted on the same edge
          if (cancel) begin
            r_buffer <= '0;
            r_count  <= '0;
          end else if (w_accept) begin
            r_buffer <= w_shifted;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          r_buffer <= '0;
          r_count  <= '0;
          if (w_match) begin
            r_fail_count <= '0;
            unlock       <= 1'b1;
            r_state      <= OPEN;
          end else if (w_fail_inc < c_max_fails) begin
            r_fail_count <= w_fail_inc[c_fail_w-1:0];
            bad_code     <= 1'b1;
            r_state      <= ENTRY;
          end else begin
            r_fail_count <= c_max_fails[c_fail_w-1:0];
            alarm        <= 1'b1;
            r_state      <= LOCKOUT;
          end
        end
        OPEN: begin
          if (lock_now) begin
            unlock  <= 1'b0;
            r_state <= ENTRY;
          end else if (change_req) begin
            unlock   <= 1'b0;
            r_buffer <= '0;
            r_count  <= '0;
            r_state  <= PROG;
          end else if (w_timer_zero) begin
            unlock  <= 1'b0;
            r_state <= ENTRY;
          end
        end
        PROG: begin
          if (cancel) begin
            r_buffer <= '0;
            r_count  <= '0;
            r_state  <= ENTRY;
          end else if (w_accept) begin
            if (w_last) begin
              r_code       <= w_shifted;
              code_changed <= 1'b1;
              r_buffer     <= '0;
              r_count      <= '0;
              r_state      <= ENTRY;
            end else begin
              r_buffer <= w_shifted;
              r_count  <= r_count + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (w_timer_zero) begin
            r_fail_count <= '0;
            alarm        <= 1'b0;
            r_state      <= ENTRY;
          end
        end
        default: begin
          r_state <= ENTRY;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_safe_lock_controller.sv
// ============================================================================
//  tb_safe_lock_controller : directed self-checking bench (lockout 8, open 4)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_safe_lock_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       cancel = 1'b0;
  logic       lock_now = 1'b0;
  logic       change_req = 1'b0;
  logic       unlock;
  logic       alarm;
  logic       bad_code;
  logic       code_changed;
  logic [1:0] fail_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  safe_lock_controller #(
    .DIGIT_W        (4),
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (8),
    .UNLOCK_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .digit_ready  (digit_ready),
    .cancel       (cancel),
    .lock_now     (lock_now),
    .change_req   (change_req),
    .unlock       (unlock),
    .alarm        (alarm),
    .bad_code     (bad_code),
    .code_changed (code_changed),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step();
    digit_valid = 1'b0;
  endtask

  // Leaves the bench in the CHECK cycle after the 4th digit (ENTRY) or in ENTRY (PROG).
  task automatic send_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) begin
      send_digit(code[i*4 +: 4]);
    end
  endtask

  task automatic relock();
    lock_now = 1'b1;
    step();
    lock_now = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_compared++; if (digit_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_ready: got %b want 1", digit_ready); end
    n_compared++; if ({unlock, alarm, bad_code, code_changed} !== 4'b0000) begin n_mismatched++; $display("FAIL reset_outputs: got %b want 0000", {unlock, alarm, bad_code, code_changed}); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_correct_entry();
    send_code(16'h1234);
    n_compared++; if (digit_ready !== 1'b0) begin n_mismatched++; $display("FAIL check_ready: got %b want 0", digit_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL open_window cycle %0d: got %b want 1", i, unlock); end
    end
    step();
    n_compared++; if (unlock !== 1'b0) begin n_mismatched++; $display("FAIL auto_relock: got %b want 0", unlock); end
    n_compared++; if (digit_ready !== 1'b1) begin n_mismatched++; $display("FAIL relock_ready: got %b want 1", digit_ready); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL correct_fail_count: got %0d want 0", fail_count); end
  endtask

  task automatic test_wrong_code();
    send_code(16'h1235);
    step();
    n_compared++; if (bad_code !== 1'b1) begin n_mismatched++; $display("FAIL bad_code_pulse: got %b want 1", bad_code); end
    n_compared++; if (fail_count !== 2'd1) begin n_mismatched++; $display("FAIL wrong_fail_count: got %0d want 1", fail_count); end
    n_compared++; if (unlock !== 1'b0) begin n_mismatched++; $display("FAIL wrong_unlock: got %b want 0", unlock); end
    step();
    n_compared++; if (bad_code !== 1'b0) begin n_mismatched++; $display("FAIL bad_code_width: got %b want 0", bad_code); end
    send_code(16'h1234);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL retry_unlock: got %b want 1", unlock); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL retry_fail_count: got %0d want 0", fail_count); end
    relock();
    n_compared++; if (unlock !== 1'b0) begin n_mismatched++; $display("FAIL lock_now: got %b want 0", unlock); end
  endtask

  task automatic test_lockout();
    for (int k = 0; k < 3; k++) begin
      send_code(16'h1235);
      step();
    end
    n_compared++; if (alarm !== 1'b1) begin n_mismatched++; $display("FAIL lockout_alarm: got %b want 1", alarm); end
    n_compared++; if (fail_count !== 2'd3) begin n_mismatched++; $display("FAIL lockout_fail_count: got %0d want 3", fail_count); end
    n_compared++; if (bad_code !== 1'b0) begin n_mismatched++; $display("FAIL lockout_no_bad_code: got %b want 0", bad_code); end
    // Digits hammered during lockout must not be accepted or queued.
    digit_valid = 1'b1;
    digit       = 4'h1;
    for (int i = 0; i < 7; i++) begin
      n_compared++; if (digit_ready !== 1'b0) begin n_mismatched++; $display("FAIL lockout_ready cycle %0d: got %b want 0", i, digit_ready); end
      step();
      n_compared++; if (alarm !== 1'b1) begin n_mismatched++; $display("FAIL lockout_hold cycle %0d: got %b want 1", i, alarm); end
    end
    step();
    digit_valid = 1'b0;
    n_compared++; if (alarm !== 1'b0) begin n_mismatched++; $display("FAIL lockout_expire: got %b want 0", alarm); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL lockout_clear_fails: got %0d want 0", fail_count); end
    send_code(16'h1234);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL post_lockout_unlock: got %b want 1", unlock); end
    relock();
  endtask

  task automatic test_cancel();
    send_digit(4'h1);
    send_digit(4'h2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    send_code(16'h1234);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL cancel_then_unlock: got %b want 1", unlock); end
    relock();
    send_digit(4'h1);
    send_digit(4'h2);
    cancel = 1'b1;
    send_digit(4'h3);
    cancel = 1'b0;
    send_digit(4'h1);
    send_digit(4'h2);
    send_digit(4'h3);
    n_compared++; if (digit_ready !== 1'b1) begin n_mismatched++; $display("FAIL cancel_digit_discarded: got ready %b want 1", digit_ready); end
    send_digit(4'h4);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL cancel_same_edge_unlock: got %b want 1", unlock); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL cancel_fail_count: got %0d want 0", fail_count); end
    relock();
  endtask

  task automatic test_reprogram();
    send_code(16'h1234);
    step();
    change_req = 1'b1;
    step();
    change_req = 1'b0;
    n_compared++; if (unlock !== 1'b0) begin n_mismatched++; $display("FAIL prog_unlock: got %b want 0", unlock); end
    n_compared++; if (digit_ready !== 1'b1) begin n_mismatched++; $display("FAIL prog_ready: got %b want 1", digit_ready); end
    send_code(16'h9876);
    n_compared++; if (code_changed !== 1'b1) begin n_mismatched++; $display("FAIL code_changed_pulse: got %b want 1", code_changed); end
    step();
    n_compared++; if (code_changed !== 1'b0) begin n_mismatched++; $display("FAIL code_changed_width: got %b want 0", code_changed); end
    send_code(16'h1234);
    step();
    n_compared++; if (bad_code !== 1'b1) begin n_mismatched++; $display("FAIL old_code_rejected: got %b want 1", bad_code); end
    send_code(16'h9876);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL new_code_unlock: got %b want 1", unlock); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL new_code_fail_count: got %0d want 0", fail_count); end
  endtask

  task automatic test_reset_mid_prog();
    change_req = 1'b1;
    step();
    change_req = 1'b0;
    send_digit(4'h5);
    send_digit(4'h5);
    reset = 1'b1;
    #1;
    n_compared++; if ({unlock, alarm, bad_code, code_changed} !== 4'b0000) begin n_mismatched++; $display("FAIL midreset_outputs: got %b want 0000", {unlock, alarm, bad_code, code_changed}); end
    n_compared++; if (fail_count !== 2'd0) begin n_mismatched++; $display("FAIL midreset_fail_count: got %0d want 0", fail_count); end
    step();
    reset = 1'b0;
    step();
    send_code(16'h1234);
    step();
    n_compared++; if (unlock !== 1'b1) begin n_mismatched++; $display("FAIL default_code_restored: got %b want 1", unlock); end
    relock();
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_wrong_code();
    test_lockout();
    test_cancel();
    test_reprogram();
    test_reset_mid_prog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
